// File: rtl/alu_issue_ctrl.sv
// Issue/forward controller for the 8-bit ALU EX stage.
// Ports: id_* in (valid/ready), flush, ex_*/wb_* slot tags out, stall_cnt (ALU_STALL_CNT_EN).
module alu_issue_ctrl #(
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_ctrl,
  input  logic            id_we,
  input  logic            id_load,
  input  logic            flush,
  output logic            ex_valid,
  output logic            ex_ctrl,
  output logic            ex_fwd,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_we,
  output logic            ex_load,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic            wb_we,
  output logic            wb_load,
  output logic [15:0]     stall_cnt
);

  typedef enum logic {RUN, STALL} st_t;

  st_t  st, st_nx;
  logic src_rd;
  logic dep_ex;
  logic dep_wb;
  logic hazard;
  logic fwd;
  logic issue;
  logic stall_now;

  // Bubble slots are all-zero, so we=0 already excludes them.
  assign src_rd = id_ctrl & (id_rs != '0);
  assign dep_ex = src_rd & ex_valid & ex_we
                & (ex_rd == id_rs);
  assign dep_wb = src_rd & wb_valid & wb_we
                & (wb_rd == id_rs);

  // The youngest producer decides.
  assign hazard = id_valid
                & (dep_ex ? ex_load
                          : (dep_wb & wb_load));
  assign fwd    = dep_ex & ~ex_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= RUN;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (flush) begin
      st_nx = RUN;
    end else begin
      unique case (st)
        RUN:   if (hazard)  st_nx = STALL;
        STALL: if (!hazard) st_nx = RUN;
        default: st_nx = RUN;
      endcase
    end
  end

  always_comb begin
    id_ready  = ~flush & ~hazard;
    issue     = id_valid & id_ready;
    stall_now = ~flush & hazard;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= 1'b0;
      ex_fwd   <= 1'b0;
      ex_rd    <= '0;
      ex_we    <= 1'b0;
      ex_load  <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      wb_load  <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      wb_rd    <= ex_rd;
      wb_we    <= ex_we;
      wb_load  <= ex_load;
      if (issue) begin
        ex_valid <= 1'b1;
        ex_ctrl  <= id_ctrl;
        ex_fwd   <= fwd;
        ex_rd    <= id_rd;
        ex_we    <= id_we;
        ex_load  <= id_load;
      end else begin
        ex_valid <= 1'b0;
        ex_ctrl  <= 1'b0;
        ex_fwd   <= 1'b0;
        ex_rd    <= '0;
        ex_we    <= 1'b0;
        ex_load  <= 1'b0;
      end
    end
  end

`ifdef ALU_STALL_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (stall_now && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign stall_cnt = cnt;
`else
  logic unused_stall;
  assign unused_stall = stall_now;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized + directed bench for alu_issue_ctrl.
// Abstract pipeline model (EX/WB array) checked every cycle.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_ready;
  logic [2:0] id_rs, id_rd;
  logic       id_ctrl, id_we, id_load, flush;
  logic       ex_valid, ex_ctrl, ex_fwd, ex_we, ex_load;
  logic [2:0] ex_rd;
  logic       wb_valid, wb_we, wb_load;
  logic [2:0] wb_rd;
  logic [15:0] stall_cnt;

  alu_issue_ctrl #(.RA_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rd(id_rd),
    .id_ctrl(id_ctrl), .id_we(id_we),
    .id_load(id_load), .flush(flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_fwd(ex_fwd), .ex_rd(ex_rd),
    .ex_we(ex_we), .ex_load(ex_load),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_load(wb_load),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       ctrl;
    logic       fwd;
    logic [2:0] rd;
    logic       we;
    logic       ld;
  } slot_t;

  // pipe[0] = EX, pipe[1] = WB
  slot_t pipe [2];
  int    m_stall;
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) pipe[i] = '{0, 0, 0, 0, 0, 0};
    m_stall = 0;
  endfunction

  // Find youngest stage writing id_rs; report stall / forward.
  function automatic void model_eval(output logic rdy,
                                     output logic fw,
                                     output logic hz);
    int src;
    src = -1;
    if (id_ctrl && id_rs != 0)
      for (int i = 1; i >= 0; i--)
        if (pipe[i].v && pipe[i].we && pipe[i].rd == id_rs)
          src = i;
    hz  = id_valid && src >= 0 && pipe[src].ld;
    fw  = src == 0 && !pipe[0].ld;
    rdy = !flush && !hz;
  endfunction

  function automatic void model_step();
    logic rdy, fw, hz;
    model_eval(rdy, fw, hz);
    if (hz && !flush && m_stall < 65535) m_stall++;
    pipe[1] = pipe[0];
    if (id_valid && rdy)
      pipe[0] = '{1, id_ctrl, fw, id_rd, id_we, id_load};
    else
      pipe[0] = '{0, 0, 0, 0, 0, 0};
  endfunction

  function automatic void compare();
    logic rdy, fw, hz;
    int   exp_cnt;
    model_eval(rdy, fw, hz);
`ifdef ALU_STALL_CNT_EN
    exp_cnt = m_stall;
`else
    exp_cnt = 0;
`endif
    chk("id_ready", id_ready, rdy);
    chk("ex_valid", ex_valid, pipe[0].v);
    chk("ex_ctrl",  ex_ctrl,  pipe[0].ctrl);
    chk("ex_fwd",   ex_fwd,   pipe[0].fwd);
    chk("ex_rd",    ex_rd,    pipe[0].rd);
    chk("ex_we",    ex_we,    pipe[0].we);
    chk("ex_load",  ex_load,  pipe[0].ld);
    chk("wb_valid", wb_valid, pipe[1].v);
    chk("wb_rd",    wb_rd,    pipe[1].rd);
    chk("wb_we",    wb_we,    pipe[1].we);
    chk("wb_load",  wb_load,  pipe[1].ld);
    chk("stall_cnt", stall_cnt, exp_cnt);
  endfunction

  task automatic cyc(input logic v, input logic [2:0] rs,
                     input logic [2:0] rd, input logic c,
                     input logic w, input logic l,
                     input logic f, output logic rdy);
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rd = rd;
    id_ctrl = c; id_we = w; id_load = l; flush = f;
    #1;
    compare();
    rdy = id_ready;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    logic r;
    cyc(0, 0, 0, 0, 0, 0, 0, r);
  endtask

  logic r;
  int   zeros;

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rd = 0;
    id_ctrl = 0; id_we = 0; id_load = 0; flush = 0;
    model_clear();
    #12;
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", id_ready, 1);

    // Independent back-to-back ops
    cyc(1, 0, 1, 0, 1, 0, 0, r);
    chk("indep1_ready", r, 1);
    cyc(1, 3, 2, 1, 1, 0, 0, r);
    chk("indep2_ready", r, 1);
    chk("indep2_fwd", ex_fwd, 0);
    chk("indep_cnt", stall_cnt, 0);
    idle(); idle();

    // ADD r2 then ADD r4<-r2 forwards
    cyc(1, 1, 2, 1, 1, 0, 0, r);
    cyc(1, 2, 4, 1, 1, 0, 0, r);
    chk("fwd_pair", ex_fwd, 1);
    idle(); idle();

    // Same pair with an unrelated op between
    cyc(1, 1, 2, 1, 1, 0, 0, r);
    cyc(1, 0, 7, 0, 1, 0, 0, r);
    cyc(1, 2, 4, 1, 1, 0, 0, r);
    chk("gap_fwd", ex_fwd, 0);
    chk("gap_valid", ex_valid, 1);
    idle(); idle();

    // Load-use: two bubbles
    cyc(1, 0, 5, 0, 1, 1, 0, r);
    zeros = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 5, 6, 1, 1, 0, 0, r);
      if (r) break;
      zeros++;
    end
    chk("loaduse_bubbles", zeros, 2);
    chk("loaduse_fwd", ex_fwd, 0);
    chk("loaduse_valid", ex_valid, 1);
`ifdef ALU_STALL_CNT_EN
    chk("loaduse_cnt", stall_cnt, 2);
`else
    chk("loaduse_cnt", stall_cnt, 0);
`endif
    idle(); idle();

    // r0 never matches
    cyc(1, 1, 0, 1, 1, 0, 0, r);
    cyc(1, 0, 1, 1, 1, 0, 0, r);
    chk("r0_ready", r, 1);
    chk("r0_fwd", ex_fwd, 0);
    idle(); idle();

    // ctrl=0 after a load of the same register
    cyc(1, 0, 5, 0, 1, 1, 0, r);
    cyc(1, 5, 7, 0, 1, 0, 0, r);
    chk("pass_b_ready", r, 1);
    idle(); idle();

    // Flush during second stall cycle
    cyc(1, 0, 5, 0, 1, 1, 0, r);
    cyc(1, 5, 6, 1, 1, 0, 0, r);
    chk("flush_st1", r, 0);
    cyc(1, 5, 6, 1, 1, 0, 1, r);
    chk("flush_rdy", r, 0);
    chk("flush_bubble", ex_valid, 0);
    cyc(1, 5, 6, 1, 1, 0, 0, r);
    chk("flush_reissue", r, 1);
    chk("flush_issued", ex_valid, 1);
    idle();

    // Reset with EX and WB both valid
    cyc(1, 0, 1, 0, 1, 0, 0, r);
    cyc(1, 0, 2, 0, 1, 0, 0, r);
    chk("pre_rst_ex", ex_valid, 1);
    chk("pre_rst_wb", wb_valid, 1);
    @(negedge clk);
    id_valid = 0;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_ex", ex_valid, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_exrd", ex_rd, 0);
    chk("rst_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 3, 0, 1, 0, 0, r);
    chk("post_rst_ex", ex_valid, 1);
    chk("post_rst_rd", ex_rd, 3);

    // Randomized traffic; hold id_* while stalled
    begin
      logic       hold, v, c, w, l, f;
      logic [2:0] rs, rd;
      hold = 0;
      v = 0; c = 0; w = 0; l = 0; rs = 0; rd = 0;
      for (int i = 0; i < 3000; i++) begin
        if (!hold) begin
          v  = $urandom_range(0, 3) != 0;
          rs = 3'($urandom_range(0, 3));
          rd = 3'($urandom_range(0, 3));
          c  = 1'($urandom_range(0, 1));
          w  = $urandom_range(0, 3) != 0;
          l  = $urandom_range(0, 2) == 0;
        end
        f = $urandom_range(0, 19) == 0;
        cyc(v, rs, rd, c, w, l, f, r);
        hold = v && !r && !f;
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
